// File: rtl/fifo_lector_if.sv
`default_nettype none
// fifo_lector_if: FIFO read port plus downstream valid/ready bundle for fifo_lector.  Rev 1.0
interface fifo_lector_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
);
   logic                  fifo_empty;
   logic [ADDR_WIDTH-1:0] fifo_data;
   logic                  fifo_valid;
   logic                  fifo_error;
   logic                  pop;
   logic                  dst_ready;
   logic [ADDR_WIDTH-1:0] data_out;
   logic                  valid;
   logic [CNT_WIDTH-1:0]  word_count;
   logic                  error;

   modport master (
      input  fifo_empty, fifo_data, fifo_valid, fifo_error, dst_ready,
      output pop, data_out, valid, word_count, error
   );

   modport slave (
      output fifo_empty, fifo_data, fifo_valid, fifo_error, dst_ready,
      input  pop, data_out, valid, word_count, error
   );
endinterface
`default_nettype wire

// File: rtl/fifo_lector.sv
`default_nettype none
// fifo_lector: FIFO read-side controller with 2-entry output buffer, word counter and sticky error.  Rev 1.0
module fifo_lector #(
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  wire logic     clk,
   input  wire logic     reset,
   fifo_lector_if.master bus
);
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic [ADDR_WIDTH-1:0] head_q, head_d;
   logic [ADDR_WIDTH-1:0] tail_q, tail_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic                  w_xfer;
   logic                  w_cap;
   logic                  w_pop;
   logic [2:0]            w_credit;

   always_comb begin
      w_xfer   = (occ_q != 2'd0) & bus.dst_ready;
      // Slots already committed: buffered words plus the outstanding read, less the one leaving now.
      w_credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, w_xfer};
      w_pop    = reset & ~bus.fifo_empty & ~err_q & (w_credit < 3'd2);
      w_cap    = bus.fifo_valid & ~((occ_q == 2'd2) & ~w_xfer);
   end

   always_comb begin
      occ_d      = occ_q;
      head_d     = head_q;
      tail_d     = tail_q;
      cnt_d      = cnt_q;
      inflight_d = w_pop;
      err_d      = err_q | bus.fifo_error | (bus.fifo_valid != inflight_q)
                 | (bus.fifo_valid & (occ_q == 2'd2) & ~w_xfer);
      if (w_xfer) begin
         cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      case ({w_xfer, w_cap})
         2'b10: begin
            occ_d = occ_q - 2'd1;
            if (occ_q == 2'd2) begin
               head_d = tail_q;
            end
         end
         2'b01: begin
            occ_d = occ_q + 2'd1;
            if (occ_q == 2'd0) begin
               head_d = bus.fifo_data;
            end else begin
               tail_d = bus.fifo_data;
            end
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               head_d = bus.fifo_data;
            end else begin
               head_d = tail_q;
               tail_d = bus.fifo_data;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   assign bus.pop        = w_pop;
   assign bus.valid      = (occ_q != 2'd0);
   assign bus.data_out   = head_q;
   assign bus.word_count = cnt_q;
   assign bus.error      = err_q;
endmodule
`default_nettype wire
